// File: rtl/sockit_spi_slv_if.sv
// Bundles the sockit SPI slave's configuration, SPI pins, byte streams and status.
// The slave modport is the responder's view; the master modport drives it.
interface sockit_spi_slv_if;
    logic       cfg_pol;
    logic       cfg_pha;
    logic       sts_clr;
    logic       spi_clk_i;
    logic       spi_ssn_i;
    logic       spi_sdi_i;
    logic       spi_sdo_o;
    logic       spi_sdo_e;
    logic [7:0] rx_dat;
    logic       rx_vld;
    logic       rx_rdy;
    logic [7:0] tx_dat;
    logic       tx_vld;
    logic       tx_rdy;
    logic       sts_act;
    logic       sts_end;
    logic       sts_ovf;
    logic       sts_udf;

    modport slave (
        input  cfg_pol, cfg_pha, sts_clr,
        input  spi_clk_i, spi_ssn_i, spi_sdi_i,
        input  rx_rdy, tx_dat, tx_vld,
        output spi_sdo_o, spi_sdo_e,
        output rx_dat, rx_vld, tx_rdy,
        output sts_act, sts_end, sts_ovf, sts_udf
    );

    modport master (
        output cfg_pol, cfg_pha, sts_clr,
        output spi_clk_i, spi_ssn_i, spi_sdi_i,
        output rx_rdy, tx_dat, tx_vld,
        input  spi_sdo_o, spi_sdo_e,
        input  rx_dat, rx_vld, tx_rdy,
        input  sts_act, sts_end, sts_ovf, sts_udf
    );
endinterface

// File: rtl/sockit_spi_slv.sv
// Oversampling SPI slave: synchronizes the SPI pins into the system clock domain,
// deserializes MOSI into bytes and serializes a byte stream onto MISO. SYN must be >= 2.
module sockit_spi_slv #(
    parameter int         SYN = 2,
    parameter logic [7:0] IDL = 8'hff
) (
    input  logic            clk,
    input  logic            rst,
    sockit_spi_slv_if.slave bus
);

    logic [SYN-1:0] clk_sync;
    logic [SYN-1:0] ssn_sync;
    logic [SYN-1:0] sdi_sync;
    logic           clk_dly;
    logic           ssn_dly;

    logic           clk_s;
    logic           ssn_s;
    logic           sdi_s;
    logic           lead;
    logic           trail;
    logic           sel;
    logic           desel;
    logic           sample;
    logic           shift;
    logic           load;
    logic           rx_done;

    logic [2:0]     cnt;
    logic [7:0]     rx_sr;
    logic [7:0]     tx_sr;
    logic [7:0]     rx_byte;
    logic [7:0]     rx_dat;
    logic           rx_vld;
    logic           act;
    logic           sdo_e;
    logic           end_pls;
    logic           ovf;
    logic           udf;

    // The SPI clock is stored polarity-normalized, so its idle level is always 0
    // and the leading edge is always a rising edge of the synchronized value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= '0;
            ssn_sync <= '1;
            sdi_sync <= '0;
            clk_dly  <= 1'b0;
            ssn_dly  <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYN-2:0], bus.spi_clk_i ^ bus.cfg_pol};
            ssn_sync <= {ssn_sync[SYN-2:0], bus.spi_ssn_i};
            sdi_sync <= {sdi_sync[SYN-2:0], bus.spi_sdi_i};
            clk_dly  <= clk_sync[SYN-1];
            ssn_dly  <= ssn_sync[SYN-1];
        end
    end

    assign clk_s   = clk_sync[SYN-1];
    assign ssn_s   = ssn_sync[SYN-1];
    assign sdi_s   = sdi_sync[SYN-1];

    assign lead    = clk_s & ~clk_dly;
    assign trail   = ~clk_s & clk_dly;
    assign sel     = ssn_dly & ~ssn_s;
    assign desel   = ~ssn_dly & ssn_s;

    // Clock edges only count while selected, and a deselect in the same cycle wins.
    assign sample  = act & ~desel & (bus.cfg_pha ? trail : lead);
    assign shift   = act & ~desel & (bus.cfg_pha ? lead : trail);
    assign load    = ~desel & ((sel & ~bus.cfg_pha) | (shift & (cnt == 3'd0)));
    assign rx_done = sample & (cnt == 3'd7);
    assign rx_byte = {rx_sr[6:0], sdi_s};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act     <= 1'b0;
            sdo_e   <= 1'b0;
            end_pls <= 1'b0;
            cnt     <= 3'd0;
            rx_sr   <= 8'h00;
        end else begin
            end_pls <= desel;
            if (desel) begin
                act   <= 1'b0;
                sdo_e <= 1'b0;
                cnt   <= 3'd0;
            end else if (sel) begin
                act   <= 1'b1;
                sdo_e <= 1'b1;
                cnt   <= 3'd0;
                rx_sr <= 8'h00;
            end else if (sample) begin
                rx_sr <= rx_byte;
                cnt   <= cnt + 3'd1;
            end
        end
    end

    // A completed byte is accepted when the holding register is empty or being
    // drained in the same cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_dat <= 8'h00;
            rx_vld <= 1'b0;
        end else if (rx_done && (!rx_vld || bus.rx_rdy)) begin
            rx_dat <= rx_byte;
            rx_vld <= 1'b1;
        end else if (rx_vld && bus.rx_rdy) begin
            rx_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_sr <= IDL;
        end else if (desel) begin
            tx_sr <= IDL;
        end else if (load) begin
            tx_sr <= bus.tx_vld ? bus.tx_dat : IDL;
        end else if (shift) begin
            tx_sr <= {tx_sr[6:0], 1'b1};
        end
    end

    // A new set condition overrides a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= (ovf & ~bus.sts_clr) | (rx_done & rx_vld & ~bus.rx_rdy);
            udf <= (udf & ~bus.sts_clr) | (load & ~bus.tx_vld);
        end
    end

    assign bus.spi_sdo_o = tx_sr[7];
    assign bus.spi_sdo_e = sdo_e;
    assign bus.rx_dat    = rx_dat;
    assign bus.rx_vld    = rx_vld;
    assign bus.tx_rdy    = load;
    assign bus.sts_act   = act;
    assign bus.sts_end   = end_pls;
    assign bus.sts_ovf   = ovf;
    assign bus.sts_udf   = udf;

endmodule

// File: tb/tb_sockit_spi_slv.sv
// Bench for sockit_spi_slv: a bit-banged SPI master plus a tx producer, with a
// scoreboard queue of expected received bytes checked by a separate rx monitor.
module tb_sockit_spi_slv;

    localparam int         SYN = 2;
    localparam logic [7:0] IDL = 8'hff;
    localparam int         H   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    sockit_spi_slv_if bus ();

    sockit_spi_slv #(.SYN(SYN), .IDL(IDL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         errors  = 0;
    int         checks  = 0;
    int         rdy_cnt = 0;
    int         end_cnt = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_q[$];
    logic [7:0] cur[$];
    bit         tx_en      = 1'b0;
    bit         model_full = 1'b0;
    bit         ovf_exp    = 1'b0;
    bit         udf_exp    = 1'b0;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Producer: presents the head of tx_q and retires it on a tx_vld/tx_rdy handshake.
    initial begin
        bit pend;
        bus.tx_vld = 1'b0;
        bus.tx_dat = 8'h00;
        forever begin
            @(negedge clk);
            pend = 1'b0;
            if (bus.tx_rdy) begin
                rdy_cnt++;
                pend = bus.tx_vld;
            end
            @(posedge clk);
            #1;
            if (pend && tx_q.size() > 0) void'(tx_q.pop_front());
            bus.tx_vld = tx_en && (tx_q.size() > 0);
            bus.tx_dat = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        end
    end

    // Rx monitor: every accepted byte must match the scoreboard head.
    always @(negedge clk) begin
        if (bus.sts_end) end_cnt++;
        if (rst && bus.rx_vld && bus.rx_rdy) begin
            if (rx_exp.size() == 0) begin
                check_output("rx_unexpected", {24'h0, bus.rx_dat}, 32'hffff_ffff);
            end else begin
                check_output("rx_dat", {24'h0, bus.rx_dat}, {24'h0, rx_exp.pop_front()});
            end
            model_full = 1'b0;
        end
    end

    task automatic spi_byte(input logic [7:0] mosi, output logic [7:0] miso, input int nbits,
                            input bit desel_last, input bit pol, input bit pha);
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_sdi_i = mosi[7-i];
            if (!pha) begin
                wait_clk(H);
                miso[7-i] = bus.spi_sdo_o;
                bus.spi_clk_i = ~pol;
                wait_clk(H);
                bus.spi_clk_i = pol;
                if (desel_last && i == nbits - 1) bus.spi_ssn_i = 1'b1;
            end else begin
                bus.spi_clk_i = ~pol;
                wait_clk(H);
                miso[7-i] = bus.spi_sdo_o;
                bus.spi_clk_i = pol;
                wait_clk(H);
            end
        end
    endtask

    // One select..deselect transaction sending cur[]; the last byte carries last_bits bits.
    task automatic apply_stimulus(input bit pol, input bit pha, input int last_bits);
        logic [7:0] exp_miso[$];
        logic [7:0] got;
        int         qn0, used, rdy0, end0, nb, last;
        bus.cfg_pol   = pol;
        bus.cfg_pha   = pha;
        bus.spi_clk_i = pol;
        wait_clk(H);
        qn0  = tx_q.size();
        last = cur.size() - 1;
        used = 0;
        for (int k = 0; k < cur.size(); k++) begin
            if (tx_en && k < qn0) begin
                exp_miso.push_back(tx_q[k]);
                used++;
            end else begin
                exp_miso.push_back(IDL);
                udf_exp = 1'b1;
            end
        end
        rdy0 = rdy_cnt;
        end0 = end_cnt;
        bus.spi_ssn_i = 1'b0;
        wait_clk(H);
        check_output("act_on", {31'h0, bus.sts_act}, 32'h1);
        check_output("sdo_e_on", {31'h0, bus.spi_sdo_e}, 32'h1);
        for (int k = 0; k <= last; k++) begin
            nb = (k == last) ? last_bits : 8;
            if (nb == 8) begin
                if (bus.rx_rdy) rx_exp.push_back(cur[k]);
                else if (!model_full) begin
                    rx_exp.push_back(cur[k]);
                    model_full = 1'b1;
                end else ovf_exp = 1'b1;
            end
            spi_byte(cur[k], got, nb, !pha && k == last, pol, pha);
            if (nb == 8) check_output("miso", {24'h0, got}, {24'h0, exp_miso[k]});
        end
        bus.spi_ssn_i = 1'b1;
        wait_clk(H);
        check_output("act_off", {31'h0, bus.sts_act}, 32'h0);
        check_output("sdo_e_off", {31'h0, bus.spi_sdo_e}, 32'h0);
        check_output("sdo_idle", {31'h0, bus.spi_sdo_o}, 32'h1);
        check_output("tx_rdy_count", rdy_cnt - rdy0, cur.size());
        check_output("tx_used", tx_q.size(), qn0 - used);
        check_output("end_pulse", end_cnt - end0, 32'h1);
        check_output("ovf", {31'h0, bus.sts_ovf}, {31'h0, ovf_exp});
        check_output("udf", {31'h0, bus.sts_udf}, {31'h0, udf_exp});
        if (bus.rx_rdy) check_output("rx_drained", rx_exp.size(), 32'h0);
    endtask

    task automatic clear_status();
        bus.sts_clr = 1'b1;
        wait_clk(1);
        bus.sts_clr = 1'b0;
        wait_clk(1);
        ovf_exp = 1'b0;
        udf_exp = 1'b0;
        check_output("ovf_clr", {31'h0, bus.sts_ovf}, 32'h0);
        check_output("udf_clr", {31'h0, bus.sts_udf}, 32'h0);
    endtask

    task automatic check_reset_outputs();
        check_output("rst_sdo_o", {31'h0, bus.spi_sdo_o}, 32'h1);
        check_output("rst_sdo_e", {31'h0, bus.spi_sdo_e}, 32'h0);
        check_output("rst_rx_dat", {24'h0, bus.rx_dat}, 32'h0);
        check_output("rst_rx_vld", {31'h0, bus.rx_vld}, 32'h0);
        check_output("rst_tx_rdy", {31'h0, bus.tx_rdy}, 32'h0);
        check_output("rst_act", {31'h0, bus.sts_act}, 32'h0);
        check_output("rst_end", {31'h0, bus.sts_end}, 32'h0);
        check_output("rst_ovf", {31'h0, bus.sts_ovf}, 32'h0);
        check_output("rst_udf", {31'h0, bus.sts_udf}, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] got;
        bus.cfg_pol   = 1'b0;
        bus.cfg_pha   = 1'b0;
        bus.sts_clr   = 1'b0;
        bus.spi_clk_i = 1'b0;
        bus.spi_ssn_i = 1'b1;
        bus.spi_sdi_i = 1'b0;
        bus.rx_rdy    = 1'b1;
        wait_clk(3);
        check_reset_outputs();
        rst = 1'b1;
        wait_clk(4);

        $display("[TB] mode 0 single byte");
        tx_en = 1'b1;
        tx_q  = '{8'hA5};
        cur   = '{8'h3C};
        apply_stimulus(1'b0, 1'b0, 8);

        $display("[TB] mode 3 three bytes");
        tx_q = '{8'h11, 8'h22, 8'h33};
        cur  = '{8'h01, 8'h80, 8'hFF};
        apply_stimulus(1'b1, 1'b1, 8);

        $display("[TB] underflow");
        tx_en = 1'b0;
        cur   = '{8'h96, 8'h69};
        apply_stimulus(1'b0, 1'b0, 8);
        clear_status();

        $display("[TB] overflow");
        tx_en      = 1'b1;
        bus.rx_rdy = 1'b0;
        tx_q       = '{8'h5E, 8'hE5};
        cur        = '{8'h12, 8'h34};
        apply_stimulus(1'b0, 1'b0, 8);
        check_output("ovf_hold_vld", {31'h0, bus.rx_vld}, 32'h1);
        check_output("ovf_hold_dat", {24'h0, bus.rx_dat}, 32'h12);
        bus.rx_rdy = 1'b1;
        wait_clk(4);
        check_output("ovf_drain_vld", {31'h0, bus.rx_vld}, 32'h0);
        check_output("ovf_drain_q", rx_exp.size(), 32'h0);
        clear_status();

        $display("[TB] partial byte then full byte");
        tx_q = '{8'h0F, 8'hF0};
        cur  = '{8'hB7};
        apply_stimulus(1'b0, 1'b0, 5);
        cur  = '{8'hC3};
        apply_stimulus(1'b0, 1'b0, 8);

        $display("[TB] reset mid-byte");
        bus.cfg_pol   = 1'b0;
        bus.cfg_pha   = 1'b0;
        bus.spi_clk_i = 1'b0;
        tx_q = '{8'h77};
        wait_clk(H);
        bus.spi_ssn_i = 1'b0;
        wait_clk(H);
        spi_byte(8'hA0, got, 3, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        rx_exp.delete();
        model_full    = 1'b0;
        ovf_exp       = 1'b0;
        udf_exp       = 1'b0;
        bus.spi_ssn_i = 1'b1;
        bus.spi_clk_i = 1'b0;
        bus.spi_sdi_i = 1'b0;
        wait_clk(4);
        rst = 1'b1;
        wait_clk(H);
        check_output("post_rst_act", {31'h0, bus.sts_act}, 32'h0);
        tx_q = '{8'h96};
        cur  = '{8'h5A};
        apply_stimulus(1'b0, 1'b0, 8);

        $display("[TB] randomized transfers");
        for (int r = 0; r < 8; r++) begin
            bit pol, pha;
            int n, m;
            pol = 1'($urandom_range(0, 1));
            pha = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 3);
            m   = $urandom_range(0, 3);
            cur.delete();
            tx_q.delete();
            for (int k = 0; k < n; k++) cur.push_back(8'($urandom));
            for (int k = 0; k < m; k++) tx_q.push_back(8'($urandom));
            tx_en = 1'($urandom_range(0, 1));
            apply_stimulus(pol, pha, 8);
            if (udf_exp || ovf_exp) clear_status();
        end

        wait_clk(4);
        check_output("rx_final_empty", rx_exp.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sockit_spi_slv.md
Name: sockit_spi_slv

Overview:
- SPI slave (responder) for the far end of the sockit SPI master link; single-bit MOSI/MISO.
- Oversamples the SPI clock, select and data pins in the system clock domain and deserializes MOSI into byte-wide read-stream words.
- Serializes a byte-wide write stream onto MISO.
- Used as the on-chip SPI target and as the loopback partner for master verification.

Parameters:
SYN, 2, synchronizer depth (flops) on spi_clk_i, spi_ssn_i, spi_sdi_i; minimum 2
IDL, 8'hff, byte driven on MISO when the write stream has no data (underflow)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  reset, asynchronous, active-low
cfg_pol  input  1  clock polarity (idle level of SPI clock); changed only while deselected
cfg_pha  input  1  clock phase (0: sample on leading edge, 1: sample on trailing edge)
sts_clr  input  1  clears sticky status flags
spi_clk_i  input  1  SPI clock from master
spi_ssn_i  input  1  slave select, active-low
spi_sdi_i  input  1  MOSI
spi_sdo_o  output  1  MISO
spi_sdo_e  output  1  MISO output enable
rx_dat  output  8  received byte
rx_vld  output  1  received byte valid
rx_rdy  input  1  consumer ready
tx_dat  input  8  byte to transmit
tx_vld  input  1  transmit byte valid
tx_rdy  output  1  transmit byte taken this cycle
sts_act  output  1  slave selected (synchronized)
sts_end  output  1  one-cycle pulse on deselect
sts_ovf  output  1  sticky receive overflow
sts_udf  output  1  sticky transmit underflow

Behaviour:
- Reset values: spi_sdo_o=1 (shift reg = IDL), spi_sdo_e=0, rx_dat=0, rx_vld=0, tx_rdy=0, sts_act=0, sts_end=0, sts_ovf=0, sts_udf=0, bit count=0, synchronizer flops = idle (clk=cfg_pol, ssn=1, sdi=0).
- Synchronize: SYN-flop chains on all three pins.
- Edge detect compares the last synchronizer stage with one extra delay flop.
- lead = cfg_pol ? fall : rise; trail = the opposite edge.
- Sample edge = cfg_pha ? trail : lead. Shift edge = the other edge.
- Latency: pin edge to internal event = SYN+1 clk cycles.
- Legal operation requires the SPI clock half-period to be at least SYN+3 clk cycles.
- Select event (synced ssn 1->0):
  - sts_act=1, spi_sdo_e=1 in the same cycle; bit count=0; rx shift reg cleared.
  - If cfg_pha=0: load event (see below).
- Clock edges while deselected are ignored.
- Sample event: rx shift reg <= {sr[6:0], sdi}; bit count increments modulo 8.
- On the 8th bit (count 7 -> 0), the byte completes:
  - If rx_vld=0, or rx_vld=1 with rx_rdy=1 in the same cycle: rx_dat <= byte, rx_vld=1.
  - Else (full): byte dropped, rx_dat kept, sts_ovf=1.
- rx_vld clears on rx_vld & rx_rdy unless a new byte completes in the same cycle.
- Shift event:
  - count==0 -> load event.
  - Otherwise the tx shift reg shifts left, filling with 1.
- Load event:
  - tx_rdy=1 for that single cycle; no prefetch buffer.
  - tx_vld=1: tx shift reg <= tx_dat.
  - tx_vld=0: tx shift reg <= IDL, sts_udf=1.
- spi_sdo_o = tx shift reg [7] at all times.
- Deselect event (synced ssn 0->1):
  - sts_act=0, spi_sdo_e=0, sts_end=1 for one cycle.
  - Partial byte discarded, no rx_vld; bit count=0; tx shift reg <= IDL; no tx_rdy.
- Simultaneous events in one cycle:
  - Deselect wins over sample/shift.
  - Select with pha=0 performs the load.
  - sts_clr with a new ovf/udf set condition: flag ends set.
- Reset mid-transfer: all state returns to reset values asynchronously. The transfer resumes only at the next select event.

Test Plan:
- Mode 0 (pol=0,pha=0), tx_dat=8'hA5 held valid, master sends 8'h3C:
  - MISO bits 1,0,1,0,0,1,0,1; rx_dat=8'h3C with one rx_vld; exactly one tx_rdy pulse, at select.
- Mode 3 (pol=1,pha=1), 3 back-to-back bytes 8'h01,8'h80,8'hFF in one select, tx stream 8'h11,8'h22,8'h33:
  - rx_dat sequence matches; MISO returns 8'h11,8'h22,8'h33; tx_rdy on each first leading edge.
- Underflow: tx_vld=0 in mode 0, 2 bytes:
  - MISO all ones for 16 bits; sts_udf=1 until sts_clr; tx_rdy pulses twice.
- Overflow: rx_rdy=0, master sends 8'h12,8'h34:
  - rx_dat=8'h12, rx_vld stays 1, sts_ovf=1.
  - Then rx_rdy=1: one transfer of 8'h12, rx_vld=0.
- Deselect after 5 bits, then full byte 8'hC3:
  - No rx_vld for the partial byte; sts_end pulse; next rx_dat=8'hC3; spi_sdo_e low while deselected.
- rst low mid-byte:
  - Outputs at reset values immediately.
  - After rst release, master reselects and sends 8'h5A: rx_dat=8'h5A.
